// File: rtl/nn_pkg.sv
// ----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the neural-layer scheduler:
//   NN_DW / NN_IN   default datapath word width and inputs per neuron
//   S_* localparams 2-bit state encoding of the layer scheduler
//   state_t         enum view of that encoding
//   nn_clog2()      ceil(log2(n)) with a minimum of 1, for index widths
// ----------------------------------------------------------------------------
package nn_pkg;

  localparam int NN_DW = 17;
  localparam int NN_IN = 13;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_ISSUE = S_ISSUE,
    ST_DRAIN = S_DRAIN,
    ST_DONE  = S_DONE
  } state_t;

  // Width needed to index 'value' entries; never less than one bit so a
  // single-neuron layer still has a legal address port.
  function automatic int nn_clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/nls_tag_pipe.sv
// ----------------------------------------------------------------------------
// nls_tag_pipe
// Delay line of {valid, neuron index} tags that tracks each issued neuron
// through the weight-ROM read and the datapath pipeline. The tail stage tells
// the output buffer when and where to write.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (clears tags)
//   flush               synchronous clear of every valid bit (wins over push)
//   in_valid, in_index  tag pushed into stage 0 on every clock
//   out_valid/out_index tail stage (stage DEPTH-1)
//   pending             some stage other than the tail holds a valid tag,
//                       i.e. a write is still to come after this cycle
// ----------------------------------------------------------------------------
module nls_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [AW-1:0] in_index,
  output logic          out_valid,
  output logic [AW-1:0] out_index,
  output logic          pending
);

  logic [DEPTH-1:0] valid;
  logic [AW-1:0]    index [DEPTH];

  // NOTE: the index stages are reset as well as the valids, because the tail
  // index is a visible output (y_addr) whose reset value is defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) index[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, so the loop order does not matter.
      valid[0] <= in_valid && !flush;
      index[0] <= in_index;
      for (int i = 1; i < DEPTH; i++) begin
        valid[i] <= valid[i-1] && !flush;
        index[i] <= index[i-1];
      end
    end
  end

  // NOTE: pending gets its default before the loop so no path through the
  // block leaves it unassigned (no latch).
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) pending = pending | valid[i];
  end

  assign out_valid = valid[DEPTH-1];
  assign out_index = index[DEPTH-1];

endmodule

// File: rtl/neuron_layer_sched.sv
// ----------------------------------------------------------------------------
// neuron_layer_sched
// Time-multiplexes one pipelined N_IN-input neuron datapath across all
// N_NEURONS neurons of a layer. A start in IDLE latches the layer input
// vector; the scheduler then issues one weight-ROM read per clock, a tag pipe
// follows each neuron through ROM and datapath latency, and the tail of that
// pipe writes the datapath result to the output buffer. done pulses once all
// writes have happened.
//
// Optional feature: define NLS_ABORT_EN to add the 'abort' input, which
// cancels a running layer (ISSUE or DRAIN) without a done pulse.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begin a layer (only looked at in IDLE)
//   abort             (NLS_ABORT_EN only) cancel the running layer
//   x_in              layer input vector, captured with the accepted start
//   busy              high while issuing and draining
//   done              one-cycle pulse after the last output write
//   w_rd_en, w_addr   weight-ROM read strobe and neuron address
//   w_data, b_data    ROM weights / bias, ROM_LAT clocks after w_rd_en
//   nx, nw, nbias     datapath inputs (latched vector, ROM pass-through)
//   ny                datapath result, NRN_LAT clocks after nx/nw/nbias
//   y_we, y_addr      output-buffer write strobe and neuron address
//   y_data            output-buffer write data (= ny)
// ----------------------------------------------------------------------------
module neuron_layer_sched
  import nn_pkg::*;
#(
  parameter int N_NEURONS = 8,
  parameter int N_IN      = NN_IN,
  parameter int DW        = NN_DW,
  parameter int ROM_LAT   = 1,
  parameter int NRN_LAT   = 2,
  parameter int AW        = nn_clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef NLS_ABORT_EN
  input  logic                 abort,
`endif
  input  logic [DW*N_IN-1:0]   x_in,
  output logic                 busy,
  output logic                 done,
  output logic                 w_rd_en,
  output logic [AW-1:0]        w_addr,
  input  logic [DW*N_IN-1:0]   w_data,
  input  logic [DW-1:0]        b_data,
  output logic [DW*N_IN-1:0]   nx,
  output logic [DW*N_IN-1:0]   nw,
  output logic [DW-1:0]        nbias,
  input  logic [DW-1:0]        ny,
  output logic                 y_we,
  output logic [AW-1:0]        y_addr,
  output logic [DW-1:0]        y_data
);

  // A tag spends one stage per clock of ROM latency plus datapath latency.
  localparam int            DEPTH = ROM_LAT + NRN_LAT;
  localparam logic [AW-1:0] LAST  = AW'(N_NEURONS - 1);

  state_t               state;
  logic [AW-1:0]        cnt;
  logic [DW*N_IN-1:0]   x_lat;
  logic                 abort_req;
  logic                 tag_pending;
  logic                 tail_valid;
  logic [AW-1:0]        tail_index;

`ifdef NLS_ABORT_EN
  assign abort_req = abort && (state == ST_ISSUE || state == ST_DRAIN);
`else
  assign abort_req = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Scheduler FSM, issue counter and input-vector latch
  // --------------------------------------------------------------------------
  // ISSUE spends one clock per neuron: each clock registers w_rd_en/w_addr for
  // the current count, so neuron k is on the ROM port one clock after the
  // count reached k. busy rises together with the first read strobe.
  //
  // DRAIN may leave as soon as no read is in flight and the only valid tag (if
  // any) sits at the tail, because that tail write completes in this very
  // cycle. DONE then registers the done pulse while returning to IDLE, so a
  // start seen in DONE is never acted on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      x_lat   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      w_rd_en <= 1'b0;
      w_addr  <= '0;
    end else begin
      done    <= 1'b0;
      w_rd_en <= 1'b0;
      if (abort_req) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              x_lat <= x_in;
              cnt   <= '0;
              state <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            busy    <= 1'b1;
            w_rd_en <= 1'b1;
            w_addr  <= cnt;
            // The counter stops at the last neuron instead of wrapping.
            if (cnt == LAST) state <= ST_DRAIN;
            else             cnt   <= cnt + AW'(1);
          end
          ST_DRAIN: begin
            if (!w_rd_en && !tag_pending) begin
              busy  <= 1'b0;
              state <= ST_DONE;
            end
          end
          ST_DONE: begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Tag pipe: one tag per read strobe, tail drives the output buffer
  // --------------------------------------------------------------------------
  nls_tag_pipe #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort_req),
    .in_valid  (w_rd_en),
    .in_index  (w_addr),
    .out_valid (tail_valid),
    .out_index (tail_index),
    .pending   (tag_pending)
  );

  // The abort gate is combinational so the write already in the tail during
  // the abort cycle is suppressed too; the flush covers the cycles after it.
  assign y_we   = tail_valid && !abort_req;
  assign y_addr = tail_index;
  assign y_data = ny;

  // Datapath drive: latched vector plus ROM words passed straight through.
  assign nx    = x_lat;
  assign nw    = w_data;
  assign nbias = b_data;

endmodule
